// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - CSR file: masked writes, exception/ertn commit, interrupt and timer state.
// Optional macro CSR_TIMER_EN enables TCFG/TVAL/TICLR and the timer interrupt IS[11].
module csr_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [13:0] csr_wnum,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wval,
  input  logic        wb_exc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] era_pc,
  output logic        has_int
);

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;

  logic [1:0]  crmd_plv_q, crmd_plv_d;
  logic        crmd_ie_q, crmd_ie_d;
  logic [1:0]  prmd_pplv_q, prmd_pplv_d;
  logic        prmd_pie_q, prmd_pie_d;
  logic [12:0] ecfg_lie_q, ecfg_lie_d;
  logic [12:0] estat_is_q, estat_is_d;
  logic [5:0]  estat_ecode_q, estat_ecode_d;
  logic [8:0]  estat_esub_q, estat_esub_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_q, badv_d;
  logic [25:0] eentry_q, eentry_d;
  logic [31:0] save_q [0:3];
  logic [31:0] save_d [0:3];
  logic [31:0] tid_q, tid_d;

  logic [31:0] crmd_val, prmd_val, ecfg_val, estat_val, eentry_val;
  logic [31:0] wdata;
  logic        timer_is;

`ifdef CSR_TIMER_EN
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        tcfg_wr, ticlr_clr, timer_fire;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] mask,
                                        input logic [31:0] val);
    return (old_v & ~mask) | (val & mask);
  endfunction

  assign crmd_val   = {28'd0, 1'b1, crmd_ie_q, crmd_plv_q};
  assign prmd_val   = {29'd0, prmd_pie_q, prmd_pplv_q};
  assign ecfg_val   = {19'd0, ecfg_lie_q};
  assign estat_val  = {1'b0, estat_esub_q, estat_ecode_q, 3'd0, estat_is_q};
  assign eentry_val = {eentry_q, 6'd0};

  always_comb begin
    csr_rvalue = 32'd0;
    case (csr_rnum)
      CSR_CRMD:   csr_rvalue = crmd_val;
      CSR_PRMD:   csr_rvalue = prmd_val;
      CSR_ECFG:   csr_rvalue = ecfg_val;
      CSR_ESTAT:  csr_rvalue = estat_val;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_BADV:   csr_rvalue = badv_q;
      CSR_EENTRY: csr_rvalue = eentry_val;
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                  csr_rvalue = save_q[csr_rnum[1:0]];
      CSR_TID:    csr_rvalue = tid_q;
`ifdef CSR_TIMER_EN
      CSR_TCFG:   csr_rvalue = tcfg_q;
      CSR_TVAL:   csr_rvalue = tval_q;
`endif
      default:    csr_rvalue = 32'd0;
    endcase
  end

  // Commit priority: exception, then ertn, then an ordinary CSR write.
  always_comb begin
    crmd_plv_d    = crmd_plv_q;
    crmd_ie_d     = crmd_ie_q;
    prmd_pplv_d   = prmd_pplv_q;
    prmd_pie_d    = prmd_pie_q;
    ecfg_lie_d    = ecfg_lie_q;
    estat_ecode_d = estat_ecode_q;
    estat_esub_d  = estat_esub_q;
    era_d         = era_q;
    badv_d        = badv_q;
    eentry_d      = eentry_q;
    tid_d         = tid_q;
    for (int i = 0; i < 4; i++) save_d[i] = save_q[i];
    wdata         = 32'd0;
    estat_is_d    = {ipi_int_in, timer_is, 1'b0, hw_int_in, estat_is_q[1:0]};
`ifdef CSR_TIMER_EN
    tcfg_wr       = 1'b0;
    ticlr_clr     = 1'b0;
`endif

    if (wb_exc) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = 2'd0;
      crmd_ie_d     = 1'b0;
      era_d         = wb_pc;
      estat_ecode_d = wb_ecode;
      estat_esub_d  = wb_esubcode;
      if (wb_ecode == ECODE_ADE && wb_esubcode == 9'd0)
        badv_d = wb_pc;
      else if (wb_ecode == ECODE_ALE)
        badv_d = wb_vaddr;
    end else if (ertn_flush) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end else if (csr_we) begin
      case (csr_wnum)
        CSR_CRMD: begin
          wdata      = merge(crmd_val, csr_wmask, csr_wval);
          crmd_plv_d = wdata[1:0];
          crmd_ie_d  = wdata[2];
        end
        CSR_PRMD: begin
          wdata       = merge(prmd_val, csr_wmask, csr_wval);
          prmd_pplv_d = wdata[1:0];
          prmd_pie_d  = wdata[2];
        end
        CSR_ECFG: begin
          wdata      = merge(ecfg_val, csr_wmask, csr_wval);
          ecfg_lie_d = wdata[12:0] & 13'h1BFF;
        end
        CSR_ESTAT: begin
          wdata            = merge(estat_val, csr_wmask, csr_wval);
          estat_is_d[1:0]  = wdata[1:0];
        end
        CSR_ERA:    era_d    = merge(era_q, csr_wmask, csr_wval);
        CSR_BADV:   badv_d   = merge(badv_q, csr_wmask, csr_wval);
        CSR_EENTRY: begin
          wdata    = merge(eentry_val, csr_wmask, csr_wval);
          eentry_d = wdata[31:6];
        end
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
          save_d[csr_wnum[1:0]] = merge(save_q[csr_wnum[1:0]], csr_wmask, csr_wval);
        CSR_TID:    tid_d    = merge(tid_q, csr_wmask, csr_wval);
`ifdef CSR_TIMER_EN
        CSR_TCFG:   tcfg_wr   = 1'b1;
        CSR_TICLR:  ticlr_clr = csr_wval[0] & csr_wmask[0];
`endif
        default: ;
      endcase
    end
  end

`ifdef CSR_TIMER_EN
  // A TCFG write reloads the counter; otherwise count down, reloading at 0 only when periodic.
  always_comb begin
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    timer_fire = 1'b0;
    if (tcfg_q[0] && tval_q != 32'd0) begin
      tval_d     = tval_q - 32'd1;
      timer_fire = (tval_q == 32'd1);
    end else if (tcfg_q[0] && tcfg_q[1]) begin
      tval_d = {tcfg_q[31:2], 2'b00};
    end
    if (tcfg_wr) begin
      tcfg_d = merge(tcfg_q, csr_wmask, csr_wval);
      tval_d = {tcfg_d[31:2], 2'b00};
    end
    if (timer_fire)
      timer_is = 1'b1;
    else if (ticlr_clr)
      timer_is = 1'b0;
    else
      timer_is = estat_is_q[11];
  end
`else
  assign timer_is = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_plv_q    <= 2'd0;
      crmd_ie_q     <= 1'b0;
      prmd_pplv_q   <= 2'd0;
      prmd_pie_q    <= 1'b0;
      ecfg_lie_q    <= 13'd0;
      estat_is_q    <= 13'd0;
      estat_ecode_q <= 6'd0;
      estat_esub_q  <= 9'd0;
      era_q         <= 32'd0;
      badv_q        <= 32'd0;
      eentry_q      <= 26'd0;
      tid_q         <= 32'd0;
      for (int i = 0; i < 4; i++) save_q[i] <= 32'd0;
`ifdef CSR_TIMER_EN
      tcfg_q        <= 32'd0;
      tval_q        <= 32'd0;
`endif
    end else begin
      crmd_plv_q    <= crmd_plv_d;
      crmd_ie_q     <= crmd_ie_d;
      prmd_pplv_q   <= prmd_pplv_d;
      prmd_pie_q    <= prmd_pie_d;
      ecfg_lie_q    <= ecfg_lie_d;
      estat_is_q    <= estat_is_d;
      estat_ecode_q <= estat_ecode_d;
      estat_esub_q  <= estat_esub_d;
      era_q         <= era_d;
      badv_q        <= badv_d;
      eentry_q      <= eentry_d;
      tid_q         <= tid_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
`ifdef CSR_TIMER_EN
      tcfg_q        <= tcfg_d;
      tval_q        <= tval_d;
`endif
    end
  end

  assign ex_entry = eentry_val;
  assign era_pc   = era_q;
  assign has_int  = (|(estat_is_q & ecfg_lie_q)) & crmd_ie_q;

endmodule
